// File: rtl/dice_roll_tracker.sv
// dice_roll_tracker: captures dice_generator results after each roll
// and keeps roll/face/streak statistics.
// Ports: clk, reset (async, active-low), roll, dice_value[2:0], clear,
//   face_sel[2:0] -> sample_valid, last_value[2:0], roll_count,
//   face_count, streak_len[3:0], double_pulse, invalid_flag.
// Optional: define DICE_TRACKER_SUM_EN for the sum_total accumulator.
module dice_roll_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             roll,
  input  logic [2:0]       dice_value,
  input  logic             clear,
  input  logic [2:0]       face_sel,
  output logic             sample_valid,
  output logic [2:0]       last_value,
  output logic [CNT_W-1:0] roll_count,
  output logic [CNT_W-1:0] face_count,
  output logic [3:0]       streak_len,
  output logic             double_pulse,
  output logic             invalid_flag
`ifdef DICE_TRACKER_SUM_EN
  ,
  output logic [CNT_W+2:0] sum_total
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ROLLING = 2'd1;
  localparam logic [1:0] SETTLE  = 2'd2;

  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             sv_q, sv_d;
  logic             dp_q, dp_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] face_q [1:6];
  logic [CNT_W-1:0] face_d [1:6];
  logic [3:0]       streak_q, streak_d;
  logic             inv_q, inv_d;
  logic             cap;
  logic             legal;

  assign cap   = (state_q == SETTLE);
  assign legal = (dice_value != 3'd0) && (dice_value != 3'd7);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (roll) state_d = ROLLING;
      ROLLING: if (!roll) state_d = SETTLE;
      SETTLE:  state_d = roll ? ROLLING : IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    sv_d     = 1'b0;
    dp_d     = 1'b0;
    last_d   = last_q;
    cnt_d    = cnt_q;
    face_d   = face_q;
    streak_d = streak_q;
    inv_d    = inv_q;
    if (clear) begin
      last_d   = 3'd0;
      cnt_d    = '0;
      streak_d = 4'd0;
      inv_d    = 1'b0;
      for (int f = 1; f <= 6; f++) face_d[f] = '0;
    end else if (cap) begin
      sv_d = 1'b1;
      if (legal) begin
        last_d = dice_value;
        if (cnt_q != CMAX) cnt_d = cnt_q + CNT_W'(1);
        for (int f = 1; f <= 6; f++) begin
          if (dice_value == 3'(f) && face_q[f] != CMAX)
            face_d[f] = face_q[f] + CNT_W'(1);
        end
        // last_q is 0 after reset/clear, never equal to a legal value
        if (dice_value == last_q) begin
          dp_d = 1'b1;
          if (streak_q != 4'd15) streak_d = streak_q + 4'd1;
        end else begin
          streak_d = 4'd1;
        end
      end else begin
        inv_d    = 1'b1;
        streak_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sv_q     <= 1'b0;
      dp_q     <= 1'b0;
      last_q   <= 3'd0;
      cnt_q    <= '0;
      streak_q <= 4'd0;
      inv_q    <= 1'b0;
      for (int f = 1; f <= 6; f++) face_q[f] <= '0;
    end else begin
      state_q  <= state_d;
      sv_q     <= sv_d;
      dp_q     <= dp_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      inv_q    <= inv_d;
      for (int f = 1; f <= 6; f++) face_q[f] <= face_d[f];
    end
  end

  always_comb begin
    face_count = '0;
    for (int f = 1; f <= 6; f++) begin
      if (face_sel == 3'(f)) face_count = face_q[f];
    end
  end

  assign sample_valid = sv_q;
  assign double_pulse = dp_q;
  assign last_value   = last_q;
  assign roll_count   = cnt_q;
  assign streak_len   = streak_q;
  assign invalid_flag = inv_q;

`ifdef DICE_TRACKER_SUM_EN
  logic [CNT_W+2:0] sum_q, sum_d;
  logic [CNT_W+3:0] sum_ext;

  assign sum_ext = {1'b0, sum_q}
                 + {{(CNT_W+1){1'b0}}, dice_value};

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (cap && legal) begin
      sum_d = sum_ext[CNT_W+3] ? {(CNT_W+3){1'b1}}
                               : sum_ext[CNT_W+2:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign sum_total = sum_q;
`endif

endmodule

// File: tb/tb_dice_roll_tracker.sv
// tb_dice_roll_tracker: directed + random stimulus on two widths
// (CNT_W=8 and CNT_W=2) against a behavioural roll/statistics model.
module tb_dice_roll_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       roll;
  logic [2:0] dice_value;
  logic       clear;
  logic [2:0] face_sel;

  logic       sv8, dp8, inv8, sv2, dp2, inv2;
  logic [2:0] lv8, lv2;
  logic [7:0] rc8, fc8;
  logic [1:0] rc2, fc2;
  logic [3:0] st8, st2;
`ifdef DICE_TRACKER_SUM_EN
  logic [10:0] sum8;
  logic [4:0]  sum2;
`endif

  always #5 clk = ~clk;

  dice_roll_tracker #(.CNT_W(8)) u8 (
    .clk(clk), .reset(reset), .roll(roll),
    .dice_value(dice_value), .clear(clear), .face_sel(face_sel),
    .sample_valid(sv8), .last_value(lv8), .roll_count(rc8),
    .face_count(fc8), .streak_len(st8), .double_pulse(dp8),
    .invalid_flag(inv8)
`ifdef DICE_TRACKER_SUM_EN
    , .sum_total(sum8)
`endif
  );

  dice_roll_tracker #(.CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .roll(roll),
    .dice_value(dice_value), .clear(clear), .face_sel(face_sel),
    .sample_valid(sv2), .last_value(lv2), .roll_count(rc2),
    .face_count(fc2), .streak_len(st2), .double_pulse(dp2),
    .invalid_flag(inv2)
`ifdef DICE_TRACKER_SUM_EN
    , .sum_total(sum2)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int sv_seen = 0;

  // Reference model: unbounded tallies, saturation applied on compare.
  // phase: 0 = waiting for roll, 1 = roll held, 2 = roll released
  int m_phase, m_rc, m_last, m_streak, m_sum;
  int m_fc [8];
  bit m_sv, m_dp, m_inv;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rc = 0; m_last = 0; m_streak = 0; m_sum = 0;
    m_sv = 0; m_dp = 0; m_inv = 0;
    for (int i = 0; i < 8; i++) m_fc[i] = 0;
  endtask

  task automatic model_edge(bit r, int d, bit c);
    bit done;
    if (c) begin
      model_reset();
      return;
    end
    done = (m_phase == 2);
    if (m_phase == 0)      m_phase = r ? 1 : 0;
    else if (m_phase == 1) m_phase = r ? 1 : 2;
    else                   m_phase = r ? 1 : 0;
    m_sv = done;
    m_dp = 0;
    if (done) begin
      if (d >= 1 && d <= 6) begin
        m_rc++;
        m_fc[d]++;
        m_sum += d;
        if (d == m_last) begin
          m_dp = 1;
          m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
        end else begin
          m_streak = 1;
        end
        m_last = d;
      end else begin
        m_inv = 1;
        m_streak = 0;
      end
    end
  endtask

  function automatic int exp_face(int w);
    int fs;
    fs = int'(face_sel);
    return (fs >= 1 && fs <= 6) ? sat(m_fc[fs], w) : 0;
  endfunction

  task automatic check_all();
    if (sv8 === 1'b1) sv_seen++;
    chk("sv8", 32'(sv8), 32'(m_sv));
    chk("dp8", 32'(dp8), 32'(m_dp));
    chk("inv8", 32'(inv8), 32'(m_inv));
    chk("last8", 32'(lv8), 32'(m_last));
    chk("rc8", 32'(rc8), 32'(sat(m_rc, 8)));
    chk("face8", 32'(fc8), 32'(exp_face(8)));
    chk("streak8", 32'(st8), 32'(m_streak));
    chk("sv2", 32'(sv2), 32'(m_sv));
    chk("dp2", 32'(dp2), 32'(m_dp));
    chk("inv2", 32'(inv2), 32'(m_inv));
    chk("last2", 32'(lv2), 32'(m_last));
    chk("rc2", 32'(rc2), 32'(sat(m_rc, 2)));
    chk("face2", 32'(fc2), 32'(exp_face(2)));
    chk("streak2", 32'(st2), 32'(m_streak));
`ifdef DICE_TRACKER_SUM_EN
    chk("sum8", 32'(sum8), 32'(sat(m_sum, 11)));
    chk("sum2", 32'(sum2), 32'(sat(m_sum, 5)));
`endif
  endtask

  task automatic step(bit r, logic [2:0] d, bit c, logic [2:0] fs);
    roll = r; dice_value = d; clear = c; face_sel = fs;
    @(posedge clk);
    model_edge(r, int'(d), c);
    #1;
    check_all();
  endtask

  task automatic roll_once(logic [2:0] d, int hold, logic [2:0] fs);
    repeat (hold) step(1'b1, d, 1'b0, fs);
    step(1'b0, d, 1'b0, fs);
    step(1'b0, d, 1'b0, fs);
    step(1'b0, d, 1'b0, fs);
  endtask

  task automatic do_reset(bit r);
    roll = r;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
  endtask

  int base;
  logic [2:0] d;

  initial begin
    reset = 1'b0; roll = 0; dice_value = 0; clear = 0; face_sel = 0;
    model_reset();
    #3;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // single roll producing 4
    sv_seen = 0;
    roll_once(3'd4, 1, 3'd4);
    chk("one_sample", 32'(sv_seen), 32'd1);
    chk("first_last", 32'(lv8), 32'd4);
    chk("first_rc", 32'(rc8), 32'd1);
    chk("first_face4", 32'(fc8), 32'd1);
    chk("first_streak", 32'(st8), 32'd1);

    // doubles then a change
    step(1'b0, 3'd0, 1'b1, 3'd3);
    step(1'b1, 3'd3, 1'b0, 3'd3);
    step(1'b0, 3'd3, 1'b0, 3'd3);
    step(1'b0, 3'd3, 1'b0, 3'd3);
    step(1'b1, 3'd3, 1'b0, 3'd3);
    step(1'b0, 3'd3, 1'b0, 3'd3);
    step(1'b0, 3'd3, 1'b0, 3'd3);
    chk("double_dp", 32'(dp8), 32'd1);
    chk("double_streak", 32'(st8), 32'd2);
    step(1'b0, 3'd3, 1'b0, 3'd3);
    roll_once(3'd5, 1, 3'd3);
    chk("change_streak", 32'(st8), 32'd1);
    chk("change_dp", 32'(dp8), 32'd0);

    // long hold counts once
    base = int'(rc8);
    sv_seen = 0;
    roll_once(3'd2, 5, 3'd2);
    chk("hold_rc", 32'(rc8), 32'(base + 1));
    chk("hold_one_sample", 32'(sv_seen), 32'd1);

    // illegal capture is sticky until clear
    base = int'(rc8);
    roll_once(3'd7, 1, 3'd7);
    chk("ill_inv", 32'(inv8), 32'd1);
    chk("ill_streak", 32'(st8), 32'd0);
    chk("ill_rc", 32'(rc8), 32'(base));
    roll_once(3'd0, 2, 3'd0);
    roll_once(3'd1, 1, 3'd1);
    chk("ill_sticky", 32'(inv8), 32'd1);

    // clear on the settle cycle wins over the capture
    step(1'b1, 3'd6, 1'b0, 3'd6);
    step(1'b0, 3'd6, 1'b0, 3'd6);
    step(1'b0, 3'd6, 1'b1, 3'd6);
    chk("clr_rc", 32'(rc8), 32'd0);
    chk("clr_last", 32'(lv8), 32'd0);
    chk("clr_sv", 32'(sv8), 32'd0);
    chk("clr_inv", 32'(inv8), 32'd0);
    step(1'b0, 3'd6, 1'b0, 3'd6);
    chk("clr_idle", 32'(sv8), 32'd0);

    // saturation at CNT_W=2
    repeat (5) roll_once(3'd6, 1, 3'd6);
    chk("sat_rc2", 32'(rc2), 32'd3);
    chk("sat_face2", 32'(fc2), 32'd3);
    chk("sat_rc8", 32'(rc8), 32'd5);
`ifdef DICE_TRACKER_SUM_EN
    chk("sat_sum2", 32'(sum2), 32'd30);
`endif

    // streak saturates at 15
    repeat (18) roll_once(3'd6, 1, 3'd6);
    chk("streak_sat", 32'(st8), 32'd15);

    // reset released with roll held keeps the roll
    do_reset(1'b1);
    step(1'b1, 3'd5, 1'b0, 3'd5);
    step(1'b0, 3'd5, 1'b0, 3'd5);
    step(1'b0, 3'd5, 1'b0, 3'd5);
    chk("rst_roll_rc", 32'(rc8), 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        d = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
      else
        d = 3'($urandom_range(1, 6));
      if (i == 1500) do_reset($urandom_range(0, 1) == 1);
      step($urandom_range(0, 9) < 4, d,
           $urandom_range(0, 99) == 0, 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
